// File: rtl/ravan_axil_regif_if.sv
// AXI4-Lite-style register bus between a host master and ravan_axil_regif.
// Ports: AW/W/B write channels and AR/R read channels; master and slave modports.
interface ravan_axil_regif_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready,
    output arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready,
    input  arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ravan_axil_regif.sv
// Register slave fronting the RAVAN crypto core: CTRL/STATUS/DIN/DOUT/KEY map.
// Ports: clk, rst (async, active high), bus (AXI-Lite slave), core_* to the core, irq.
module ravan_axil_regif #(
  parameter int DATA_W   = 64,
  parameter int KEY_W    = 512,
  parameter int ADDR_W   = 16,
  parameter int CORE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  ravan_axil_regif_if.slave bus,
  output logic              core_enc_sel,
  output logic              core_mode,
  output logic [DATA_W-1:0] core_data_in,
  output logic [KEY_W-1:0]  core_key,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_sha_error,
  output logic              irq
);
  localparam int KEY_WORDS = KEY_W / DATA_W;
  localparam int BSH = $clog2(DATA_W / 8);
  localparam int AW  = ADDR_W - BSH;
  localparam int KIW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  localparam logic [AW-1:0] I_CTRL = '0;
  localparam logic [AW-1:0] I_STAT = AW'(8 >> BSH);
  localparam logic [AW-1:0] I_DIN  = AW'(16 >> BSH);
  localparam logic [AW-1:0] I_DOUT = AW'(24 >> BSH);
  localparam logic [AW-1:0] I_KEY  = AW'(64 >> BSH);
  localparam logic [AW-1:0] I_KEND = AW'((64 >> BSH) + KEY_WORDS);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fin;

  logic                           bvalid_q, rvalid_q;
  logic [1:0]                     bresp_q, rresp_q;
  logic [DATA_W-1:0]              rdata_q;
  logic                           ctrl_mode_q, core_mode_q;
  logic                           done_q, sha_q, irq_q;
  logic [DATA_W-1:0]              din_q, dout_q;
  logic [KEY_WORDS-1:0][DATA_W-1:0] key_q;

  logic [AW-1:0]  wa, ra, wk_ofs, rk_ofs;
  logic [KIW-1:0] wk, rk;
  logic           wa_ctrl, wa_din, wa_key;
  logic           ra_ctrl, ra_stat, ra_din, ra_dout, ra_key;
  logic           busy, wr_fire, ar_fire;
  logic           w_ctrl, w_din, w_key, w_ok;
  logic           do_ctrl, do_din, do_key, start_go, dout_rd;
  logic [DATA_W-1:0] rd_d;
  logic              r_ok;
  logic              unused_ok;

  assign wa = bus.awaddr[ADDR_W-1:BSH];
  assign ra = bus.araddr[ADDR_W-1:BSH];
  assign wk_ofs = wa - I_KEY;
  assign rk_ofs = ra - I_KEY;
  assign wk = wk_ofs[KIW-1:0];
  assign rk = rk_ofs[KIW-1:0];

  // Byte-lane bits and high key-offset bits carry no information here.
  assign unused_ok = ^{bus.awaddr[BSH-1:0], bus.araddr[BSH-1:0],
                       wk_ofs[AW-1:KIW], rk_ofs[AW-1:KIW]};

  assign wa_ctrl = (wa == I_CTRL);
  assign wa_din  = (wa == I_DIN);
  assign wa_key  = (wa >= I_KEY) && (wa < I_KEND);
  assign ra_ctrl = (ra == I_CTRL);
  assign ra_stat = (ra == I_STAT);
  assign ra_din  = (ra == I_DIN);
  assign ra_dout = (ra == I_DOUT);
  assign ra_key  = (ra >= I_KEY) && (ra < I_KEND);

  assign busy    = (state_q == S_RUN);
  assign wr_fire = bus.awvalid && bus.wvalid && !bvalid_q;
  assign ar_fire = bus.arvalid && !rvalid_q;

  // Operand registers are frozen while the core runs.
  always_comb begin
    w_ctrl = 1'b0;
    w_din  = 1'b0;
    w_key  = 1'b0;
    unique case (1'b1)
      wa_ctrl: w_ctrl = !busy;
      wa_din:  w_din  = !busy;
      wa_key:  w_key  = !busy;
      default: ;
    endcase
  end

  assign w_ok     = w_ctrl || w_din || w_key;
  assign do_ctrl  = wr_fire && w_ctrl;
  assign do_din   = wr_fire && w_din;
  assign do_key   = wr_fire && w_key;
  assign start_go = do_ctrl && bus.wdata[0];
  assign dout_rd  = ar_fire && ra_dout;

  always_comb begin
    rd_d = '0;
    r_ok = 1'b1;
    unique case (1'b1)
      ra_ctrl: rd_d[1]   = ctrl_mode_q;
      ra_stat: rd_d[2:0] = {sha_q, done_q, busy};
      ra_din:  rd_d      = din_q;
      ra_dout: rd_d      = dout_q;
      ra_key:  rd_d      = key_q[rk];
      default: r_ok      = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_RUN;
          cnt_d   = 8'(CORE_LAT);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
          fin     = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (start_go) begin
          state_d = S_RUN;
          cnt_d   = 8'(CORE_LAT);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= OKAY;
      rdata_q     <= '0;
      ctrl_mode_q <= 1'b0;
      core_mode_q <= 1'b0;
      done_q      <= 1'b0;
      sha_q       <= 1'b0;
      irq_q       <= 1'b0;
      din_q       <= '0;
      dout_q      <= '0;
      key_q       <= '0;
    end else begin
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_ok ? OKAY : SLVERR;
      end else if (bvalid_q && bus.bready) begin
        bvalid_q <= 1'b0;
      end

      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_d;
        rresp_q  <= r_ok ? OKAY : SLVERR;
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end

      if (do_ctrl)  ctrl_mode_q <= bus.wdata[1];
      if (start_go) core_mode_q <= bus.wdata[1];
      if (do_din)   din_q       <= bus.wdata;
      if (do_key)   key_q[wk]   <= bus.wdata;

      // A completion wins over a same-cycle DOUT read clearing done.
      if (fin)
        done_q <= 1'b1;
      else if (start_go || dout_rd)
        done_q <= 1'b0;

      if (fin)
        sha_q <= core_sha_error;
      else if (start_go)
        sha_q <= 1'b0;

      if (fin) dout_q <= core_data_out;
      irq_q <= fin;
    end
  end

  assign bus.awready  = wr_fire;
  assign bus.wready   = wr_fire;
  assign bus.bvalid   = bvalid_q;
  assign bus.bresp    = bresp_q;
  assign bus.arready  = ar_fire;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rresp    = rresp_q;

  assign core_enc_sel = busy;
  assign core_mode    = core_mode_q;
  assign core_data_in = din_q;
  assign core_key     = key_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_ravan_axil_regif.sv
// Directed bench for ravan_axil_regif with a stub core and vector table.
// Ports: none; drives the AXI-Lite interface and models the core result.
module tb_ravan_axil_regif;
  localparam int DW  = 64;
  localparam int KW  = 512;
  localparam int AW  = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ravan_axil_regif_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          core_enc_sel, core_mode, irq, core_sha_error;
  logic [DW-1:0] core_data_in, core_data_out;
  logic [KW-1:0] core_key;

  ravan_axil_regif #(
    .DATA_W(DW), .KEY_W(KW), .ADDR_W(AW), .CORE_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .core_enc_sel(core_enc_sel),
    .core_mode(core_mode),
    .core_data_in(core_data_in),
    .core_key(core_key),
    .core_data_out(core_data_out),
    .core_sha_error(core_sha_error),
    .irq(irq)
  );

  function automatic logic [63:0] core_f(input logic [63:0] d,
                                         input logic [511:0] k,
                                         input logic m);
    core_f = m ? (d ^ k[63:0] ^ k[511:448]) : (d + k[127:64]);
  endfunction

  function automatic logic [63:0] kv(input int i);
    kv = {32'hC0DE0000 + 32'(i), 32'h13579BDF ^ (32'(i) << 8)};
  endfunction

  assign core_data_out = core_enc_sel ?
    core_f(core_data_in, core_key, core_mode) : '0;

  int n_chk = 0;
  int n_fail = 0;
  int irq_n = 0;
  int run_n = 0;
  int aw_n = 0;
  int ar_n = 0;

  always @(negedge clk) begin
    if (irq) irq_n++;
    if (core_enc_sel) run_n++;
    if (bus.awready) aw_n++;
    if (bus.arready) ar_n++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  task automatic axi_wr(input logic [15:0] a, input logic [63:0] d,
                        output logic [1:0] resp);
    bit ok;
    resp = 2'bxx;
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.wvalid  = 1'b1;
    bus.wdata   = d;
    bus.bready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.awready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!ok) tout("awready");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.bvalid) begin
        resp = bus.bresp;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tout("bvalid");
    @(posedge clk);
    #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [15:0] a, output logic [63:0] d,
                        output logic [1:0] resp);
    bit ok;
    resp = 2'bxx;
    d = 'x;
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    bus.rready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    if (!ok) tout("arready");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        resp = bus.rresp;
        d = bus.rdata;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tout("rvalid");
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
  endtask

  task automatic wr_chk(input string nm, input logic [15:0] a,
                        input logic [63:0] d, input logic [1:0] er);
    logic [1:0] r;
    axi_wr(a, d, r);
    chk({nm, ".bresp"}, 64'(r), 64'(er));
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a,
                        input logic [63:0] ed, input logic [1:0] er);
    logic [1:0]  r;
    logic [63:0] d;
    axi_rd(a, d, r);
    chk({nm, ".rresp"}, 64'(r), 64'(er));
    chk({nm, ".rdata"}, d, ed);
  endtask

  task automatic wait_irq(input string nm, input int base);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (irq_n > base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tout(nm);
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [63:0] d;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] DIN0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] DIN1 = 64'hFEDCBA9876543210;

  logic [511:0] kall;
  logic [63:0]  exp_enc, exp_dec, v_old;
  int ib, rb, awb, arb;

  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    core_sha_error = 1'b0;
    for (int i = 0; i < 8; i++) kall[i*64 +: 64] = kv(i);
    exp_enc = core_f(DIN0, kall, 1'b1);
    exp_dec = core_f(DIN0, kall, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.irq", 64'(irq), 0);
    chk("rst.enc_sel", 64'(core_enc_sel), 0);
    chk("rst.mode", 64'(core_mode), 0);
    chk("rst.din", core_data_in, 0);
    chk("rst.key_zero", 64'(core_key == '0), 1);
    chk("rst.bvalid", 64'(bus.bvalid), 0);
    chk("rst.rvalid", 64'(bus.rvalid), 0);
    chk("rst.rdata", bus.rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 16'h0040 + 16'(i * 8), kv(i), 2'b00});
    tbl.push_back('{1'b1, 16'h0010, DIN0, 2'b00});
    tbl.push_back('{1'b0, 16'h0010, DIN0, 2'b00});
    tbl.push_back('{1'b0, 16'h0013, DIN0, 2'b00});
    tbl.push_back('{1'b0, 16'h0058, kv(3), 2'b00});
    tbl.push_back('{1'b0, 16'h0078, kv(7), 2'b00});
    tbl.push_back('{1'b0, 16'h0008, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0018, 64'h0, 2'b00});
    tbl.push_back('{1'b0, 16'h0020, 64'h0, 2'b10});
    tbl.push_back('{1'b0, 16'h0080, 64'h0, 2'b10});
    tbl.push_back('{1'b0, 16'h0038, 64'h0, 2'b10});
    tbl.push_back('{1'b1, 16'h0018, 64'h55, 2'b10});
    tbl.push_back('{1'b1, 16'h0008, 64'h7, 2'b10});
    tbl.push_back('{1'b1, 16'h0020, 64'h1, 2'b10});
    tbl.push_back('{1'b0, 16'h0018, 64'h0, 2'b00});
    tbl.push_back('{1'b1, 16'h0000, 64'h2, 2'b00});
    tbl.push_back('{1'b0, 16'h0000, 64'h2, 2'b00});
    tbl.push_back('{1'b0, 16'h0008, 64'h0, 2'b00});

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (tbl[i].wr) wr_chk(nm, tbl[i].a, tbl[i].d, tbl[i].resp);
      else rd_chk(nm, tbl[i].a, tbl[i].d, tbl[i].resp);
    end
    chk("key_routing", 64'(core_key == kall), 1);
    chk("din_routing", core_data_in, DIN0);

    // Encrypt run.
    ib = irq_n; rb = run_n;
    wr_chk("enc.start", 16'h0000, 64'h3, 2'b00);
    wait_irq("enc.irq", ib);
    chk("enc.irq_pulses", 64'(irq_n - ib), 1);
    chk("enc.busy_cycles", 64'(run_n - rb), LAT);
    chk("enc.core_mode", 64'(core_mode), 1);
    rd_chk("enc.status", 16'h0008, 64'h2, 2'b00);
    rd_chk("enc.dout", 16'h0018, exp_enc, 2'b00);
    rd_chk("enc.status_clr", 16'h0008, 64'h0, 2'b00);
    rd_chk("enc.ctrl", 16'h0000, 64'h2, 2'b00);

    // Decrypt run.
    ib = irq_n;
    wr_chk("dec.start", 16'h0000, 64'h1, 2'b00);
    wait_irq("dec.irq", ib);
    chk("dec.core_mode", 64'(core_mode), 0);
    rd_chk("dec.dout", 16'h0018, exp_dec, 2'b00);

    // Operands frozen while busy.
    ib = irq_n;
    wr_chk("busy.start", 16'h0000, 64'h3, 2'b00);
    wr_chk("busy.din", 16'h0010, DIN1, 2'b10);
    chk("busy.core_din", core_data_in, DIN0);
    wait_irq("busy.irq", ib);
    rd_chk("busy.dout", 16'h0018, exp_enc, 2'b00);
    rd_chk("busy.din_rb", 16'h0010, DIN0, 2'b00);

    // Backpressure on both channels; read sees pre-write DIN.
    awb = aw_n; arb = ar_n;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 16'h0010; bus.wvalid = 1'b1;
    bus.wdata = DIN1; bus.bready = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 16'h0010; bus.rready = 1'b0;
    #1;
    chk("bp.awready", 64'(bus.awready), 1);
    chk("bp.arready", 64'(bus.arready), 1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp.bvalid%0d", i), 64'(bus.bvalid), 1);
      chk($sformatf("bp.bresp%0d", i), 64'(bus.bresp), 0);
      chk($sformatf("bp.rvalid%0d", i), 64'(bus.rvalid), 1);
      chk($sformatf("bp.rdata%0d", i), bus.rdata, DIN0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("bp.aw_pulses", 64'(aw_n - awb), 1);
    chk("bp.ar_pulses", 64'(ar_n - arb), 1);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    @(negedge clk);
    chk("bp.bvalid_drop", 64'(bus.bvalid), 0);
    chk("bp.rvalid_drop", 64'(bus.rvalid), 0);
    rd_chk("bp.din_new", 16'h0010, DIN1, 2'b00);

    // Decode errors leave DOUT alone.
    wr_chk("dec.wr_dout", 16'h0018, 64'h1234, 2'b10);
    rd_chk("dec.dout_keep", 16'h0018, exp_enc, 2'b00);

    // Sticky sha error.
    core_sha_error = 1'b1;
    ib = irq_n;
    wr_chk("sha.start", 16'h0000, 64'h3, 2'b00);
    wait_irq("sha.irq", ib);
    core_sha_error = 1'b0;
    rd_chk("sha.status", 16'h0008, 64'h6, 2'b00);
    rd_chk("sha.dout", 16'h0018, core_f(DIN1, kall, 1'b1), 2'b00);
    rd_chk("sha.status2", 16'h0008, 64'h4, 2'b00);
    ib = irq_n;
    wr_chk("sha.restart", 16'h0000, 64'h3, 2'b00);
    rd_chk("sha.status3", 16'h0008, 64'h1, 2'b00);
    wait_irq("sha.irq2", ib);
    rd_chk("sha.dout2", 16'h0018, core_f(DIN1, kall, 1'b1), 2'b00);

    // DOUT read on the completing edge: old data, done survives.
    v_old = core_f(DIN1, kall, 1'b1);
    ib = irq_n;
    wr_chk("race.start", 16'h0000, 64'h1, 2'b00);
    @(posedge clk);
    rd_chk("race.dout_old", 16'h0018, v_old, 2'b00);
    rd_chk("race.status", 16'h0008, 64'h2, 2'b00);
    rd_chk("race.dout_new", 16'h0018, core_f(DIN1, kall, 1'b0), 2'b00);
    chk("race.irq_pulses", 64'(irq_n - ib), 1);

    // Reset in the middle of a run.
    ib = irq_n;
    wr_chk("mid.start", 16'h0000, 64'h3, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    chk("mid.enc_sel", 64'(core_enc_sel), 0);
    chk("mid.din", core_data_in, 0);
    chk("mid.key_zero", 64'(core_key == '0), 1);
    chk("mid.mode", 64'(core_mode), 0);
    chk("mid.irq", 64'(irq), 0);
    repeat (5) @(posedge clk);
    chk("mid.no_irq", 64'(irq_n - ib), 0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("mid.status", 16'h0008, 64'h0, 2'b00);
    rd_chk("mid.dout", 16'h0018, 64'h0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
